// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between two one-word readers.
// Define ROM_RD_CNT_EN to add the rd_count_o completed-read counter.
module rom_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_dout_i,
    output logic              busy_o
`ifdef ROM_RD_CNT_EN
    ,
    output logic [15:0]       rd_count_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t            state_q;
    logic              owner_q;
    logic              last_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              busy_q;
    logic              owner_d;
    logic [ADDR_W-1:0] addr_d;

    // Round-robin pick: on a tie the port that was not served last wins.
    always_comb begin
        owner_d = 1'b0;
        if (req0_i && req1_i) begin
            owner_d = ~last_q;
        end else if (req1_i) begin
            owner_d = 1'b1;
        end else begin
            owner_d = 1'b0;
        end
        addr_d = owner_d ? addr1_i : addr0_i;
    end

    // Grant/read FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= {DATA_W{1'b0}};
            rdata1_q   <= {DATA_W{1'b0}};
            rom_addr_q <= {ADDR_W{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid0_q <= 1'b0;
                    rvalid1_q <= 1'b0;
                    if (req0_i || req1_i) begin
                        owner_q    <= owner_d;
                        rom_addr_q <= addr_d;
                        gnt0_q     <= ~owner_d;
                        gnt1_q     <= owner_d;
                        busy_q     <= 1'b1;
                        state_q    <= READ;
                    end else begin
                        gnt0_q <= 1'b0;
                        gnt1_q <= 1'b0;
                    end
                end
                READ: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    if (owner_q) begin
                        rdata1_q  <= rom_dout_i;
                        rvalid1_q <= 1'b1;
                    end else begin
                        rdata0_q  <= rom_dout_i;
                        rvalid0_q <= 1'b1;
                    end
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ROM_RD_CNT_EN
    logic [15:0] rd_count_q;

    // Counts completed reads; advances on the edge that raises rvalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_count_q <= 16'd0;
        end else if (state_q == READ) begin
            rd_count_q <= rd_count_q + 16'd1;
        end else begin
            rd_count_q <= rd_count_q;
        end
    end

    assign rd_count_o = rd_count_q;
`endif

    assign gnt0_o     = gnt0_q;
    assign gnt1_o     = gnt1_q;
    assign rvalid0_o  = rvalid0_q;
    assign rvalid1_o  = rvalid1_q;
    assign rdata0_o   = rdata0_q;
    assign rdata1_o   = rdata1_q;
    assign rom_addr_o = rom_addr_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_rom_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] addr0 = 4'd0;
    logic [3:0] addr1 = 4'd0;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [7:0] rdata0, rdata1, rom_dout;
    logic [3:0] rom_addr;
`ifdef ROM_RD_CNT_EN
    logic [15:0] rd_count;
`endif

    logic [7:0] rom [16];
    assign rom_dout = rom[rom_addr];

    rom_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req0_i     (req0),
        .addr0_i    (addr0),
        .gnt0_o     (gnt0),
        .rvalid0_o  (rvalid0),
        .rdata0_o   (rdata0),
        .req1_i     (req1),
        .addr1_i    (addr1),
        .gnt1_o     (gnt1),
        .rvalid1_o  (rvalid1),
        .rdata1_o   (rdata1),
        .rom_addr_o (rom_addr),
        .rom_dout_i (rom_dout),
        .busy_o     (busy)
`ifdef ROM_RD_CNT_EN
        ,
        .rd_count_o (rd_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs as seen by the active edge
    logic       s_rst = 1'b1;
    logic       s_req [2];
    logic [3:0] s_addr [2];
    always @(posedge clk) begin
        s_rst     <= rst;
        s_req[0]  <= req0;
        s_req[1]  <= req1;
        s_addr[0] <= addr0;
        s_addr[1] <= addr1;
    end

    // Transaction-level reference: a read in flight completes one edge after its grant
    bit         m_inflight = 1'b0;
    int         m_owner = 0;
    int         m_last = 1;
    bit         m_gnt [2];
    bit         m_rv [2];
    logic [7:0] m_rdata [2];
    logic [3:0] m_addr = 4'd0;
    logic [7:0] m_pend = 8'd0;
    int         m_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (s_rst) begin
                m_inflight = 1'b0; m_last = 1; m_owner = 0; m_addr = 4'd0; m_cnt = 0;
                for (int p = 0; p < 2; p++) begin
                    m_gnt[p] = 1'b0; m_rv[p] = 1'b0; m_rdata[p] = 8'd0;
                end
            end else if (m_inflight) begin
                m_gnt[0] = 1'b0; m_gnt[1] = 1'b0;
                m_rv[m_owner] = 1'b1;
                m_rdata[m_owner] = m_pend;
                m_last = m_owner;
                m_inflight = 1'b0;
                m_cnt = (m_cnt + 1) % 65536;
            end else begin
                m_gnt[0] = 1'b0; m_gnt[1] = 1'b0;
                m_rv[0] = 1'b0; m_rv[1] = 1'b0;
                if (s_req[0] || s_req[1]) begin
                    if (s_req[0] && s_req[1]) m_owner = 1 - m_last;
                    else m_owner = s_req[0] ? 0 : 1;
                    m_addr = s_addr[m_owner];
                    m_pend = rom[m_addr];
                    m_gnt[m_owner] = 1'b1;
                    m_inflight = 1'b1;
                end
            end
            if (chk_en) begin
                chk("gnt0", 32'(gnt0), 32'(m_gnt[0]));
                chk("gnt1", 32'(gnt1), 32'(m_gnt[1]));
                chk("rvalid0", 32'(rvalid0), 32'(m_rv[0]));
                chk("rvalid1", 32'(rvalid1), 32'(m_rv[1]));
                chk("rdata0", 32'(rdata0), 32'(m_rdata[0]));
                chk("rdata1", 32'(rdata1), 32'(m_rdata[1]));
                chk("rom_addr", 32'(rom_addr), 32'(m_addr));
                chk("busy", 32'(busy), 32'(m_inflight));
                chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
                chk("rvalid_exclusive", 32'(rvalid0 & rvalid1), 32'd0);
`ifdef ROM_RD_CNT_EN
                chk("rd_count", 32'(rd_count), 32'(m_cnt));
`endif
            end
        end
    end

    // One read on port p, bounded wait for the grant; ends on the rvalid cycle
    task automatic do_read(input int p, input logic [3:0] a);
        bit got = 1'b0;
        if (p == 0) begin req0 = 1'b1; addr0 = a; end
        else begin req1 = 1'b1; addr1 = a; end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ((p == 0) ? gnt0 : gnt1) begin
                got = 1'b1;
                break;
            end
        end
        chk("do_read_gnt", 32'(got), 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(1, 255));

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);

        // 2: single read on port0
        req0 = 1'b1; addr0 = 4'd3;
        @(negedge clk);
        chk("t2_gnt0", 32'(gnt0), 32'd1);
        chk("t2_gnt1", 32'(gnt1), 32'd0);
        chk("t2_rom_addr", 32'(rom_addr), 32'd3);
        chk("t2_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        chk("t2_rvalid0", 32'(rvalid0), 32'd1);
        chk("t2_rdata0", 32'(rdata0), 32'(rom[3]));
        chk("t2_gnt0_pulse", 32'(gnt0), 32'd0);
        chk("t2_rvalid1", 32'(rvalid1), 32'd0);

        // 3: simultaneous requests right after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; addr0 = 4'd2; req1 = 1'b1; addr1 = 4'd5;
        @(negedge clk);
        chk("t3_gnt0_first", 32'({gnt0, gnt1}), 32'b10);
        req0 = 1'b0;
        @(negedge clk);
        chk("t3_rvalid0", 32'(rvalid0), 32'd1);
        chk("t3_rdata0", 32'(rdata0), 32'(rom[2]));
        chk("t3_no_gnt_in_read", 32'({gnt0, gnt1}), 32'd0);
        @(negedge clk);
        chk("t3_gnt1_second", 32'({gnt0, gnt1}), 32'b01);
        req1 = 1'b0;
        @(negedge clk);
        chk("t3_rvalid1", 32'(rvalid1), 32'd1);
        chk("t3_rdata1", 32'(rdata1), 32'(rom[5]));

        // 4: both held high for 12 cycles -> alternating grants every 2 cycles
        req0 = 1'b1; addr0 = 4'd7; req1 = 1'b1; addr1 = 4'd9;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t4_gnt0", 32'(gnt0), 32'((k % 4) == 0));
            chk("t4_gnt1", 32'(gnt1), 32'((k % 4) == 2));
            chk("t4_busy", 32'(busy), 32'((k % 2) == 0));
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // 5: reset in the READ cycle drops the transaction
        req1 = 1'b1; addr1 = 4'd15;
        @(negedge clk);
        chk("t5_gnt1", 32'(gnt1), 32'd1);
        rst = 1'b1; req1 = 1'b0;
        @(negedge clk);
        chk("t5_no_rvalid1", 32'(rvalid1), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_rdata1", 32'(rdata1), 32'd0);
        rst = 1'b0; req1 = 1'b1; addr1 = 4'd15;
        @(negedge clk);
        chk("t5_regnt1", 32'(gnt1), 32'd1);
        chk("t5_rom_addr", 32'(rom_addr), 32'd15);
        req1 = 1'b0;
        @(negedge clk);
        chk("t5_rdata1_rom15", 32'(rdata1), 32'(rom[15]));

`ifdef ROM_RD_CNT_EN
        // 6: read counter
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_read(0, 4'd1);
        do_read(1, 4'd4);
        do_read(1, 4'd15);
        do_read(0, 4'd0);
        do_read(1, 4'd8);
        @(negedge clk);
        chk("t6_rd_count5", 32'(rd_count), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rd_count_rst", 32'(rd_count), 32'd0);
        rst = 1'b0;
`else
        do_read(0, 4'd1);
        do_read(1, 4'd15);
        chk("t6_rdata1_rom15", 32'(rdata1), 32'(rom[15]));
`endif

        // Random traffic with protocol-following requesters and sporadic reset
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 39) == 0);
            if (gnt0) begin
                req0 = 1'b0; addr0 = 4'($urandom);
            end else if (!req0 && ($urandom_range(0, 2) == 0)) begin
                req0 = 1'b1; addr0 = 4'($urandom);
            end
            if (gnt1) begin
                req1 = 1'b0; addr1 = 4'($urandom);
            end else if (!req1 && ($urandom_range(0, 2) == 0)) begin
                req1 = 1'b1; addr1 = 4'($urandom);
            end
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
